// File: rtl/rv32_regfile_alu_unit.sv
// Execute-stage datapath slice: 32x32 register file (2R/1W, x0 hardwired
// to zero), one-hot controlled ALU (add only for now) and a 3-to-8 one-hot
// funct3 decoder. All outputs are combinational; the register array is the
// only state.
module rv32_regfile_alu_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int ALU_OP_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr1,
    output logic [DATA_WIDTH-1:0]   rdata1,
    input  logic [ADDR_WIDTH-1:0]   raddr2,
    output logic [DATA_WIDTH-1:0]   rdata2,
    input  logic [DATA_WIDTH-1:0]   src1,
    input  logic [DATA_WIDTH-1:0]   src2,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [2:0]              dec_in,
    output logic [7:0]              dec_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Register array: reset clears everything and wins over a concurrent
    // write; writes to x0 are dropped so its storage stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: no write bypass, so a same-cycle write shows the old value;
    // x0 is masked explicitly rather than relying on its storage.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end

    // ALU: OR of the results of every selected one-hot operation; only bit0
    // (add, carry discarded) is populated, reserved bits contribute zero.
    always_comb begin
        alu_result = '0;
        if (alu_op[0]) begin
            alu_result = alu_result | (src1 + src2);
        end
    end

    // funct3 decoder: exactly one bit set for every input value.
    always_comb begin
        dec_out = 8'h01 << dec_in;
    end

endmodule

// File: tb/tb_rv32_regfile_alu_unit.sv
// Self-checking bench for rv32_regfile_alu_unit: directed plan followed by
// randomized traffic compared against a behavioural array model.
module tb_rv32_regfile_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [0:0]  alu_op;
    logic [31:0] alu_result;
    logic [2:0]  dec_in;
    logic [7:0]  dec_out;

    int errors = 0;
    int checks = 0;

    // Architectural view of the register file.
    logic [31:0] model [32];

    rv32_regfile_alu_unit #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .ALU_OP_WIDTH(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .src1      (src1),
        .src2      (src2),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .dec_in    (dec_in),
        .dec_out   (dec_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    function automatic logic [31:0] exp_alu(input logic [0:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return op[0] ? 32'(s % 64'h1_0000_0000) : 32'h0;
    endfunction

    function automatic logic [7:0] exp_dec(input logic [2:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (int'(d) == i);
        return r;
    endfunction

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wen && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, rdata1, exp_read(raddr1));
        check({tag, "_rd2"}, rdata2, exp_read(raddr2));
    endtask

    initial begin
        reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; src1 = '0; src2 = '0; alu_op = '0; dec_in = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        tick();
        reset = 1'b0;

        // Reset state on every index, both ports.
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            check("reset_rd1", rdata1, 32'h0);
            check("reset_rd2", rdata2, 32'h0);
        end

        // Write x5, old value visible in the write cycle.
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check("rdw_old", rdata1, 32'h0);
        tick();
        wen = 1'b0;
        #1;
        check("x5_rd1", rdata1, 32'hDEADBEEF);
        check("x5_rd2", rdata2, 32'hDEADBEEF);

        // x0 write ignored, wen=0 leaves state untouched.
        wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0;
        tick();
        wen = 1'b0;
        #1;
        check("x0_zero", rdata1, 32'h0);
        waddr = 5'd5; wdata = 32'h1; raddr1 = 5'd5;
        tick();
        #1;
        check("wen0_hold", rdata1, 32'hDEADBEEF);

        // ALU directed cases.
        alu_op = 1'b1; src1 = 32'h3; src2 = 32'h4; #1;
        check("alu_3p4", alu_result, 32'h7);
        src1 = 32'hFFFFFFFF; src2 = 32'h1; #1;
        check("alu_wrap", alu_result, 32'h0);
        src1 = 32'h80000000; src2 = 32'h80000000; #1;
        check("alu_msb", alu_result, 32'h0);
        alu_op = 1'b0; src1 = 32'h3; src2 = 32'h4; #1;
        check("alu_none", alu_result, 32'h0);

        // Decoder sweep.
        for (int i = 0; i < 8; i++) begin
            dec_in = 3'(i);
            #1;
            check("dec_sweep", {24'h0, dec_out}, {24'h0, 8'h01 << i});
        end

        // Reset beats a write on the same edge.
        wen = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D; raddr1 = 5'd10; raddr2 = 5'd5;
        tick();
        #1;
        check("x10_written", rdata1, 32'hCAFEF00D);
        reset = 1'b1; wdata = 32'h55;
        tick();
        reset = 1'b0; wen = 1'b0;
        #1;
        check("x10_reset", rdata1, 32'h0);
        check("x5_reset", rdata2, 32'h0);
        wen = 1'b1; waddr = 5'd10; wdata = 32'h55;
        #1;
        check("x10_pre", rdata1, 32'h0);
        tick();
        wen = 1'b0;
        #1;
        check("x10_post", rdata1, 32'h55);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 31) == 0);
            wen    = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 7) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            src1   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            src2   = $urandom;
            alu_op = 1'($urandom_range(0, 1));
            dec_in = 3'($urandom_range(0, 7));
            check_reads("rand");
            check("rand_alu", alu_result, exp_alu(alu_op, src1, src2));
            check("rand_dec", {24'h0, dec_out}, {24'h0, exp_dec(dec_in)});
            tick();
        end
        reset = 1'b0; wen = 1'b0;

        // Final sweep of the whole file.
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i);
            check_reads("final");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_regfile_alu_unit.md
Name: rv32_regfile_alu_unit

Overview:
Execute-stage datapath slice for the single-cycle RV32 core. It contains three parts:
- a 32x32 integer register file with two combinational read ports and one synchronous write port;
- a one-hot-controlled ALU (currently add only);
- a 3-to-8 one-hot decoder used for funct3 decode.

The top level drives rs1/rs2/rd, write-back data and ALU operands, and consumes the read data, ALU result and decoded funct3.

Parameters:
- DATA_WIDTH, 32, width of registers, ALU operands and result.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).
- ALU_OP_WIDTH, 1, width of the one-hot ALU operation select.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wen  input  1  register-file write enable.
- waddr  input  ADDR_WIDTH  write register index (rd).
- wdata  input  DATA_WIDTH  write-back data.
- raddr1  input  ADDR_WIDTH  read port 1 index (rs1).
- rdata1  output  DATA_WIDTH  read port 1 data.
- raddr2  input  ADDR_WIDTH  read port 2 index (rs2).
- rdata2  output  DATA_WIDTH  read port 2 data.
- src1  input  DATA_WIDTH  ALU operand A.
- src2  input  DATA_WIDTH  ALU operand B.
- alu_op  input  ALU_OP_WIDTH  one-hot ALU operation; bit0 = add.
- alu_result  output  DATA_WIDTH  ALU result.
- dec_in  input  3  decoder input (funct3).
- dec_out  output  8  one-hot decoder output.

Behaviour:

Clocking and reset:
- Single clock domain.
- reset is synchronous, active-high. On a rising clk edge with reset=1, all 32 registers clear to 0, and any write on that edge is discarded.
- Outputs are combinational, so they have no reset value of their own. After the reset edge, rdata1 and rdata2 read 0 for every index.

Register file:
- Register x0 is hardwired to zero. Reads of index 0 return 0 always. Writes to index 0 are ignored (the storage may exist but must never be visible).
- Write: on a rising edge with reset=0, wen=1 and waddr!=0, regs[waddr] <= wdata.
- If wen=0, no state changes.
- Read: rdata1 = regs[raddr1] and rdata2 = regs[raddr2], purely combinational, zero latency.
- Both ports may read the same index simultaneously.
- Read-during-write: there is no bypass. In the cycle of the write, the read shows the old value; the new value appears after the edge.
- Latency: written data is visible on the read ports one edge after the write is presented.

ALU:
- Purely combinational, zero latency.
- alu_op[0]=1: alu_result = src1 + src2, modulo 2**DATA_WIDTH (carry discarded, no flags).
- alu_op all zero: alu_result = 0.
- Further one-hot bits are reserved for future operations. Unassigned bits contribute 0 to the result. When several bits are set, the result is the bitwise OR of the selected operation results.

Decoder:
- Purely combinational.
- dec_out[i] = 1 if and only if dec_in == i; exactly one bit is set for every input.

General:
- No X propagation from the register file after reset.
- No internal state other than the register array.

Test Plan:
1. Reset, then read all indices 0..31 on both ports -> all rdata = 0x00000000.
2. wen=1, waddr=5, wdata=0xDEADBEEF, one edge; raddr1=5, raddr2=5 -> both 0xDEADBEEF. Before the edge (same cycle as the write), rdata1 = 0.
3. wen=1, waddr=0, wdata=0x12345678, one edge; raddr1=0 -> 0x00000000. Then wen=0, waddr=5, wdata=0x1, one edge -> x5 still 0xDEADBEEF.
4. ALU with alu_op=1:
   - 0x00000003+0x00000004 -> 0x00000007
   - 0xFFFFFFFF+0x00000001 -> 0x00000000
   - 0x80000000+0x80000000 -> 0x00000000
   - alu_op=0 -> 0x00000000
5. Decoder: sweep dec_in 0..7 -> dec_out = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80.
6. Write x10=0xCAFEF00D, then assert reset with wen=1, waddr=10, wdata=0x55 on the same edge -> x10 reads 0 after the edge. Deassert reset; the next write of 0x55 to x10 is visible after one edge.
